// File: rtl/iob_rsp_router_fifo.sv
// iob_rsp_router_fifo: in-order queue of grant indices for outstanding requests
module iob_rsp_router_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [W-1:0]     i_data,
   input  logic             i_pop,
   output logic [W-1:0]     o_head,
   output logic [CNT_W-1:0] o_count
);
   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_cnt;

   assign o_head  = r_mem[r_rd];
   assign o_count = r_cnt;

   // pointers wrap modulo DEPTH; fullness/emptiness is tracked only by the counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem <= '{default: '0};
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (i_pop) r_rd <= r_rd + 1'b1;
         if (i_push && !i_pop) r_cnt <= r_cnt + 1'b1;
         else if (i_pop && !i_push) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/iob_rsp_router.sv
// iob_rsp_router: steers in-order subordinate responses to the requester that issued them
module iob_rsp_router #(
   parameter int PORTS  = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int IDX_W = $clog2(PORTS),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_valid_i,
   input  logic [IDX_W-1:0]        issue_index_i,
   output logic                    issue_ready_o,
   input  logic                    sub_rsp_valid_i,
   input  logic [DATA_W-1:0]       sub_rsp_data_i,
   output logic                    sub_rsp_ready_o,
   output logic [PORTS-1:0]        rsp_valid_o,
   output logic [PORTS*DATA_W-1:0] rsp_data_o,
   input  logic [PORTS-1:0]        rsp_ready_i,
   output logic [CNT_W-1:0]        outstanding_o,
   output logic                    unexpected_o
);
   logic [IDX_W-1:0] w_head;
   logic [PORTS-1:0] w_sel;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             r_unexpected;

   iob_rsp_router_fifo #(.W(IDX_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (issue_index_i),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (outstanding_o)
   );

   assign issue_ready_o = outstanding_o != CNT_W'(DEPTH);
   assign w_push        = issue_valid_i && issue_ready_o;
   assign w_empty       = outstanding_o == '0;
   assign w_sel         = PORTS'(1) << w_head;
   assign w_pop         = sub_rsp_valid_i && sub_rsp_ready_o && !w_empty;
   assign unexpected_o  = r_unexpected;
   assign rsp_data_o    = {PORTS{sub_rsp_data_i}};

   // responses with nothing outstanding are swallowed so the subordinate never stalls
   always_comb begin
      rsp_valid_o     = (sub_rsp_valid_i && !w_empty) ? w_sel : '0;
      sub_rsp_ready_o = w_empty ? 1'b1 : |(rsp_ready_i & w_sel);
   end

   // sticky record of any response that had no matching request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_unexpected <= 1'b0;
      else if (sub_rsp_valid_i && w_empty) r_unexpected <= 1'b1;
   end
endmodule

// File: tb/tb_iob_rsp_router.sv
// tb_iob_rsp_router: directed self-checking bench for the response router
module tb_iob_rsp_router;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         issue_valid_i = 1'b0;
   logic [1:0]   issue_index_i = '0;
   logic         issue_ready_o;
   logic         sub_rsp_valid_i = 1'b0;
   logic [31:0]  sub_rsp_data_i = '0;
   logic         sub_rsp_ready_o;
   logic [3:0]   rsp_valid_o;
   logic [127:0] rsp_data_o;
   logic [3:0]   rsp_ready_i = 4'hF;
   logic [2:0]   outstanding_o;
   logic         unexpected_o;
   int           n_chk = 0;
   int           n_pass = 0;
   int           q[$];

   iob_rsp_router #(.PORTS(4), .DATA_W(32), .DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .issue_valid_i   (issue_valid_i),
      .issue_index_i   (issue_index_i),
      .issue_ready_o   (issue_ready_o),
      .sub_rsp_valid_i (sub_rsp_valid_i),
      .sub_rsp_data_i  (sub_rsp_data_i),
      .sub_rsp_ready_o (sub_rsp_ready_o),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_data_o      (rsp_data_o),
      .rsp_ready_i     (rsp_ready_i),
      .outstanding_o   (outstanding_o),
      .unexpected_o    (unexpected_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx);
      issue_valid_i = 1'b1;
      issue_index_i = 2'(idx);
      tick();
      issue_valid_i = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_out", 64'(outstanding_o), 0);
      chk("rst_irdy", 64'(issue_ready_o), 1);
      chk("rst_rv", 64'(rsp_valid_o), 0);
      chk("rst_unexp", 64'(unexpected_o), 0);
      chk("rst_srdy", 64'(sub_rsp_ready_o), 1);

      issue(2);
      issue(0);
      issue(3);
      chk("iss3_out", 64'(outstanding_o), 3);
      for (int k = 0; k < 3; k++) begin
         int port;
         port = (k == 0) ? 2 : (k == 1) ? 0 : 3;
         sub_rsp_valid_i = 1'b1;
         sub_rsp_data_i = 32'hA + 32'(k);
         #1;
         chk("ord_rv", 64'(rsp_valid_o), 64'(4'b1 << port));
         chk("ord_data", 64'(rsp_data_o[port*32 +: 32]), 64'(32'hA + 32'(k)));
         chk("ord_srdy", 64'(sub_rsp_ready_o), 1);
         tick();
         sub_rsp_valid_i = 1'b0;
         chk("ord_out", 64'(outstanding_o), 64'(2 - k));
      end

      issue(1);
      rsp_ready_i = 4'b1101;
      sub_rsp_valid_i = 1'b1;
      sub_rsp_data_i = 32'h55;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_srdy", 64'(sub_rsp_ready_o), 0);
         chk("bp_rv", 64'(rsp_valid_o), 64'(4'b0010));
         tick();
         chk("bp_out", 64'(outstanding_o), 1);
      end
      rsp_ready_i = 4'hF;
      #1;
      chk("bp_rel_srdy", 64'(sub_rsp_ready_o), 1);
      tick();
      sub_rsp_valid_i = 1'b0;
      chk("bp_rel_out", 64'(outstanding_o), 0);

      for (int k = 0; k < 4; k++) issue(k);
      chk("full_irdy", 64'(issue_ready_o), 0);
      chk("full_out", 64'(outstanding_o), 4);
      issue(2);
      chk("full_ign_out", 64'(outstanding_o), 4);
      issue_valid_i = 1'b1;
      issue_index_i = 2'd2;
      sub_rsp_valid_i = 1'b1;
      sub_rsp_data_i = 32'h77;
      #1;
      chk("full_ret_rv", 64'(rsp_valid_o), 64'(4'b0001));
      tick();
      issue_valid_i = 1'b0;
      chk("full_ret_out", 64'(outstanding_o), 3);
      chk("full_ret_irdy", 64'(issue_ready_o), 1);
      #1;
      chk("drain1_rv", 64'(rsp_valid_o), 64'(4'b0010));
      tick();
      sub_rsp_valid_i = 1'b0;
      chk("cnt2_out", 64'(outstanding_o), 2);

      q = '{2, 3};
      for (int k = 0; k < 10; k++) begin
         int idx;
         idx = (k * 3 + 1) % 4;
         issue_valid_i = 1'b1;
         issue_index_i = 2'(idx);
         sub_rsp_valid_i = 1'b1;
         sub_rsp_data_i = 32'h100 + 32'(k);
         #1;
         chk("wrap_rv", 64'(rsp_valid_o), 64'(4'b1 << q[0]));
         chk("wrap_data", 64'(rsp_data_o[q[0]*32 +: 32]), 64'(32'h100 + 32'(k)));
         tick();
         void'(q.pop_front());
         q.push_back(idx);
         chk("wrap_out", 64'(outstanding_o), 2);
      end
      issue_valid_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("wdrain_rv", 64'(rsp_valid_o), 64'(4'b1 << q[0]));
         tick();
         void'(q.pop_front());
      end
      sub_rsp_valid_i = 1'b0;
      chk("wdrain_out", 64'(outstanding_o), 0);

      rsp_ready_i = 4'h0;
      sub_rsp_valid_i = 1'b1;
      #1;
      chk("unx_srdy", 64'(sub_rsp_ready_o), 1);
      chk("unx_rv", 64'(rsp_valid_o), 0);
      chk("unx_pre", 64'(unexpected_o), 0);
      tick();
      sub_rsp_valid_i = 1'b0;
      rsp_ready_i = 4'hF;
      chk("unx_set", 64'(unexpected_o), 1);
      tick();
      tick();
      chk("unx_hold", 64'(unexpected_o), 1);
      chk("unx_out", 64'(outstanding_o), 0);

      issue(1);
      issue(2);
      issue(3);
      chk("mid_out", 64'(outstanding_o), 3);
      sub_rsp_valid_i = 1'b1;
      rsp_ready_i = 4'h0;
      rst = 1'b1;
      #1;
      chk("mrst_out", 64'(outstanding_o), 0);
      chk("mrst_irdy", 64'(issue_ready_o), 1);
      chk("mrst_rv", 64'(rsp_valid_o), 0);
      chk("mrst_unexp", 64'(unexpected_o), 0);
      chk("mrst_srdy", 64'(sub_rsp_ready_o), 1);
      tick();
      rst = 1'b0;
      tick();
      sub_rsp_valid_i = 1'b0;
      chk("post_rst_unexp", 64'(unexpected_o), 1);
      chk("post_rst_out", 64'(outstanding_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/iob_rsp_router.md
Name: iob_rsp_router

Overview:
- Return-path companion to the request arbiter.
- Once a granted request is accepted by the shared subordinate, it records the grant index in an in-order outstanding queue.
- Routes each subordinate response back to the requester port that issued the oldest outstanding request.
- Sits between one shared subordinate's response channel and PORTS requester response channels.
- Responses are strictly in order: the subordinate returns responses in issue order.

Parameters:
- PORTS, 4: number of requester ports; legal range 2..16.
- DATA_W, 32: response data width.
- DEPTH, 4: maximum outstanding requests; power of two, >= 2.
- IDX_W, $clog2(PORTS): index width (localparam).
- CNT_W, $clog2(DEPTH+1): outstanding counter width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- issue_valid_i  in  1  a request was accepted by the subordinate this cycle.
- issue_index_i  in  IDX_W  grant index of that request (arbiter encoded grant).
- issue_ready_o  out  1  queue can record an issue; arbiter must gate subordinate acceptance with it.
- sub_rsp_valid_i  in  1  subordinate response valid.
- sub_rsp_data_i  in  DATA_W  subordinate response data.
- sub_rsp_ready_o  out  1  router accepts the subordinate response.
- rsp_valid_o  out  PORTS  per-port response valid, one-hot or zero.
- rsp_data_o  out  PORTS*DATA_W  per-port data; port p occupies bits [p*DATA_W +: DATA_W].
- rsp_ready_i  in  PORTS  per-port response ready.
- outstanding_o  out  CNT_W  number of queued outstanding requests.
- unexpected_o  out  1  sticky flag: a response arrived with an empty queue.

Behaviour:
- Reset (async assert, sync release): queue empty, rd/wr pointers 0, outstanding_o=0, unexpected_o=0, issue_ready_o=1, rsp_valid_o=0.
- Queue:
  - DEPTH entries of IDX_W bits; head = oldest entry.
  - Entry is written on issue_valid_i && issue_ready_o; visible at head from the next cycle (no same-cycle bypass).
- issue_ready_o = (outstanding_o != DEPTH), registered-state-derived.
  - When full, it stays 0 even if a retire happens in the same cycle. No same-cycle full pass-through.
  - issue_valid_i while issue_ready_o=0 is ignored (protocol violation; no state change).
- Routing is combinational from the head, zero latency. Let h = head index.
  - Non-empty queue:
    - rsp_valid_o[h] = sub_rsp_valid_i; all other valid bits 0.
    - sub_rsp_ready_o = rsp_ready_i[h].
    - Every port's rsp_data_o slice = sub_rsp_data_i; only valid qualifies it.
  - Retire: sub_rsp_valid_i && sub_rsp_ready_o && queue non-empty. Pops the head at the clock edge.
  - Empty queue:
    - rsp_valid_o=0, sub_rsp_ready_o=1, and the response is discarded.
    - If sub_rsp_valid_i=1, unexpected_o is set at the next edge and held until reset.
- Simultaneous issue and retire (queue not full, not empty): both happen; outstanding_o is unchanged; pointers both advance.
- Pointer wrap: rd/wr pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from the counter, not pointer compare.
- outstanding_o is +1 on issue only, -1 on retire only, unchanged on both or neither. Range 0..DEPTH.
- Reset mid-operation clears all queued indices. In-flight responses after reset count as unexpected.
- No combinational path from rsp_ready_i to issue_ready_o.

Decomposition:
- No shared package needed. IDX_W and CNT_W are local parameters.
- One sub-module, iob_rsp_router_fifo: DEPTH x IDX_W synchronous FIFO with push, pop, head, and count. Async reset, no bypass.
- Top level holds the routing mux/demux and the unexpected flag.

Test Plan:
- Reset, then idle: outstanding_o=0, issue_ready_o=1, rsp_valid_o=4'b0000, unexpected_o=0.
- Issue indices 2,0,3, then return responses 0xA,0xB,0xC with all ready=1:
  - rsp_valid_o goes 4'b0100, 4'b0001, 4'b1000 in turn.
  - Data matches each response.
  - outstanding_o steps 3,2,1,0.
- Backpressure: head=1, rsp_ready_i[1]=0 for 5 cycles with sub_rsp_valid_i=1:
  - sub_rsp_ready_o=0 and outstanding_o holds.
  - Raising rsp_ready_i[1] retires in that cycle.
- Fill 4 issues: issue_ready_o=0. A 5th issue_valid_i is ignored. Issue plus retire in the same cycle while full does not record the issue; after that edge outstanding_o=3 and issue_ready_o=1.
- Continuous issue+retire for 10 cycles at count 2: outstanding_o stays 2, pointers wrap, routing order is preserved.
- Response with empty queue: sub_rsp_ready_o=1, rsp_valid_o=0, and unexpected_o=1 from the next cycle until rst. Assert rst mid-burst (3 outstanding): all outputs return to reset values immediately.
